// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display driver.
// Segments are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_DIGITS = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

  // Index 15 (F) is leftmost, index 0 (0) is rightmost.
  localparam logic [15:0][SEG_W-1:0] GLYPH = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 32-bit binary to 10 BCD digits, one shift per cycle.
// done is high during the cycle whose closing edge performs the final shift.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        done,
  output logic [39:0] bcd
);

  localparam int unsigned BIN_W = 32;
  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned SH_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = 5;

  logic [SH_W-1:0]  r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic [SH_W-1:0]  w_adj;

  // Add 3 to every BCD nibble that is 5 or more before the shift.
  always_comb begin
    w_adj = r_sh;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (w_adj[BIN_W + 4*i +: 4] >= 4'd5)
        w_adj[BIN_W + 4*i +: 4] = w_adj[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  assign done = r_active && (r_cnt == CNT_W'(BIN_W - 1));
  assign bcd  = r_sh[SH_W-1:BIN_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh     <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_sh     <= {BCD_W'(0), bin};
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_sh  <= {w_adj[SH_W-2:0], 1'b0};
      r_cnt <= r_cnt + CNT_W'(1);
      if (done) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_display_driver.sv
// Eight-digit seven-segment driver: accepts a 32-bit value (hex or decimal),
// commits a complete glyph set atomically, and scans it onto a multiplexed display.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid,
  input  logic [31:0]                         wr_data,
  output logic                                wr_ready,
  input  logic                                dec_mode,
  output logic                                busy,
  output logic                                overflow,
  output logic [NUM_DIGITS-1:0][SEG_W-1:0]    out_data,
  output logic [NUM_DIGITS-1:0]               an,
  output logic [SEG_W-1:0]                    seg
);

  localparam int unsigned RCNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

  state_e                           r_state, w_state_nxt;
  logic                             r_ready, r_busy, r_ovf, r_dec;
  logic [31:0]                      r_data;
  logic                             w_accept, w_start, w_commit;
  logic                             w_conv_done;
  logic [39:0]                      w_bcd;
  logic [NUM_DIGITS-1:0][3:0]       w_dig;
  logic                             w_ovf, w_seen;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] w_disp, w_out_nxt, r_out;
  logic [RCNT_W-1:0]                r_rcnt;
  logic [IDX_W-1:0]                 r_idx, w_idx_nxt;
  logic                             w_wrap;
  logic [NUM_DIGITS-1:0]            r_an;
  logic [SEG_W-1:0]                 r_seg;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .bin   (wr_data),
    .done  (w_conv_done),
    .bcd   (w_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (wr_valid) w_state_nxt = dec_mode ? CONVERT : COMMIT;
      CONVERT: if (w_conv_done) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_start  = 1'b0;
    w_commit = 1'b0;
    if (r_state == IDLE) w_accept = wr_valid;
    w_start = w_accept && dec_mode;
    if (r_state == COMMIT) w_commit = 1'b1;
  end

  // Digit selection, overflow, and leading-zero blanking from the top digit down.
  always_comb begin
    w_ovf  = r_dec && (w_bcd[39:32] != 8'd0);
    w_seen = 1'b0;
    w_disp = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++)
      w_dig[i] = r_dec ? w_bcd[4*i +: 4] : r_data[4*i +: 4];
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      w_seen = w_seen || (w_dig[i] != 4'd0);
      if (w_ovf)                                   w_disp[i] = SEG_DASH;
      else if ((BLANK_LZ != 0) && !w_seen && (i != 0)) w_disp[i] = SEG_BLANK;
      else                                         w_disp[i] = GLYPH[w_dig[i]];
    end
  end

  assign w_out_nxt = w_commit ? w_disp : r_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_dec   <= 1'b0;
      r_data  <= '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++)
        r_out[i] <= ((i == 0) || (BLANK_LZ == 0)) ? GLYPH[0] : SEG_BLANK;
    end else begin
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_data <= wr_data;
        r_dec  <= dec_mode;
      end
      if (w_commit) r_ovf <= w_ovf;
      r_out <= w_out_nxt;
    end
  end

  // Scan runs free of the FSM; an/seg follow the index and display they will hold.
  assign w_wrap    = (r_rcnt == RCNT_W'(REFRESH_DIV - 1));
  assign w_idx_nxt = w_wrap ? r_idx + IDX_W'(1) : r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt <= '0;
      r_idx  <= '0;
      r_an   <= ~NUM_DIGITS'(1);
      r_seg  <= GLYPH[0];
    end else begin
      r_rcnt <= w_wrap ? '0 : r_rcnt + RCNT_W'(1);
      r_idx  <= w_idx_nxt;
      r_an   <= ~(NUM_DIGITS'(1) << w_idx_nxt);
      r_seg  <= w_out_nxt[w_idx_nxt];
    end
  end

  assign wr_ready = r_ready;
  assign busy     = r_busy;
  assign overflow = r_ovf;
  assign out_data = r_out;
  assign an       = r_an;
  assign seg      = r_seg;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: scoreboard of expected displays
// pushed at each offer and popped when the block returns to ready.
module tb_seg_display_driver;

  localparam int unsigned DIV = 4;
  localparam int unsigned ND  = 8;

  typedef logic [ND-1:0][6:0] disp_t;
  typedef struct packed { disp_t d; logic ovf; } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        dec_mode = 1'b0;
  logic        wr_ready, busy, overflow;
  disp_t       out_data;
  logic [7:0]  an;
  logic [6:0]  seg;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  logic [6:0] tb_glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .dec_mode(dec_mode), .busy(busy), .overflow(overflow),
    .out_data(out_data), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [31:0] v, input logic dec);
    exp_t            e;
    logic [3:0]      dg [ND];
    longint unsigned x;
    int              msd;
    x     = longint'(v);
    e.ovf = dec && (v > 32'd99999999);
    for (int i = 0; i < int'(ND); i++) begin
      if (dec) begin dg[i] = 4'(x % 10); x = x / 10; end
      else dg[i] = v[4*i +: 4];
    end
    msd = 0;
    for (int i = 0; i < int'(ND); i++) if (dg[i] != 4'd0) msd = i;
    for (int i = 0; i < int'(ND); i++) begin
      if (e.ovf)        e.d[i] = 7'b0111111;
      else if (i > msd) e.d[i] = 7'b1111111;
      else              e.d[i] = tb_glyph[dg[i]];
    end
    return e;
  endfunction

  // Present one value; returns at the sample point just after the accept edge.
  task automatic offer(input logic [31:0] v, input logic dec);
    wr_valid = 1'b1; wr_data = v; dec_mode = dec;
    exp_q.push_back(model(v, dec));
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Cycles from accept until wr_ready returns; pre is the display one sample earlier.
  task automatic wait_idle(output int lat, output disp_t pre);
    lat = -1;
    pre = out_data;
    for (int c = 1; c <= 60; c++) begin
      pre = out_data;
      @(negedge clk);
      if (wr_ready === 1'b1) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    disp_t rd;
    rst = 1'b1; wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd = model(32'd0, 1'b1).d;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (out_data !== rd) begin n_bad++; $display("FAIL reset_out_data got %h want %h", out_data, rd); end
    n_cmp++; if (an !== 8'b11111110) begin n_bad++; $display("FAIL reset_an got %b want 11111110", an); end
    n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL reset_seg got %b want 1000000", seg); end
  endtask

  // Starts on the first sample after reset release: counter 0, index 0.
  task automatic test_scan();
    logic [7:0] ea;
    logic [6:0] es;
    int         idx;
    for (int k = 0; k < int'(9 * DIV); k++) begin
      idx = (k / int'(DIV)) % 8;
      ea  = ~(8'b1 << idx);
      es  = (idx == 0) ? 7'b1000000 : 7'b1111111;
      n_cmp++; if (an !== ea) begin n_bad++; $display("FAIL scan_an k=%0d got %b want %b", k, an, ea); end
      n_cmp++; if (seg !== es) begin n_bad++; $display("FAIL scan_seg k=%0d got %b want %b", k, seg, es); end
      @(negedge clk);
    end
  endtask

  task automatic test_hex();
    logic [31:0] vals [3];
    disp_t       old, pre;
    exp_t        e;
    int          lat;
    vals[0] = 32'hDEADBEEF; vals[1] = 32'h00000A00; vals[2] = 32'h00000000;
    for (int t = 0; t < 3; t++) begin
      old = out_data;
      offer(vals[t], 1'b0);
      n_cmp++; if (wr_ready !== 1'b0 || busy !== 1'b1)
        begin n_bad++; $display("FAIL hex_busy v=%h got ready=%b busy=%b want 0/1", vals[t], wr_ready, busy); end
      wait_idle(lat, pre);
      e = exp_q.pop_front();
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL hex_latency v=%h got %0d want 1", vals[t], lat); end
      n_cmp++; if (pre !== old) begin n_bad++; $display("FAIL hex_early_update v=%h got %h want %h", vals[t], pre, old); end
      n_cmp++; if (out_data !== e.d) begin n_bad++; $display("FAIL hex_out_data v=%h got %h want %h", vals[t], out_data, e.d); end
      n_cmp++; if (overflow !== e.ovf) begin n_bad++; $display("FAIL hex_overflow v=%h got %b want %b", vals[t], overflow, e.ovf); end
    end
  endtask

  task automatic test_decimal();
    logic [31:0] vals [7];
    disp_t       old, pre;
    exp_t        e;
    int          lat;
    vals[0] = 32'd12345;     vals[1] = 32'd100000000; vals[2] = 32'd99999999;
    vals[3] = 32'd0;         vals[4] = 32'hFFFFFFFF;
    vals[5] = 32'($urandom_range(0, 99999999));
    vals[6] = 32'($urandom_range(0, 9999));
    for (int t = 0; t < 7; t++) begin
      old = out_data;
      offer(vals[t], 1'b1);
      wait_idle(lat, pre);
      e = exp_q.pop_front();
      n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL dec_latency v=%0d got %0d want 33", vals[t], lat); end
      n_cmp++; if (pre !== old) begin n_bad++; $display("FAIL dec_early_update v=%0d got %h want %h", vals[t], pre, old); end
      n_cmp++; if (out_data !== e.d) begin n_bad++; $display("FAIL dec_out_data v=%0d got %h want %h", vals[t], out_data, e.d); end
      n_cmp++; if (overflow !== e.ovf) begin n_bad++; $display("FAIL dec_overflow v=%0d got %b want %b", vals[t], overflow, e.ovf); end
    end
  endtask

  task automatic test_ignored_offer();
    exp_t e;
    int   lat, stray;
    logic rdy_at_offer;
    rdy_at_offer = 1'b1;
    offer(32'd7, 1'b1);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin wr_valid = 1'b1; wr_data = 32'h55; dec_mode = 1'b0; rdy_at_offer = wr_ready; end
      if (c == 6) wr_valid = 1'b0;
      @(negedge clk);
      if (c >= 6 && wr_ready === 1'b1) begin lat = c; break; end
    end
    e = exp_q.pop_front();
    n_cmp++; if (rdy_at_offer !== 1'b0) begin n_bad++; $display("FAIL ignore_ready_low got %b want 0", rdy_at_offer); end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL ignore_latency got %0d want 33", lat); end
    n_cmp++; if (out_data !== e.d) begin n_bad++; $display("FAIL ignore_out_data got %h want %h", out_data, e.d); end
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wr_ready !== 1'b1 || out_data !== e.d) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL ignore_no_second_commit got %0d bad cycles want 0", stray); end
  endtask

  task automatic test_reset_mid_convert();
    disp_t rd;
    int    stray;
    rd = model(32'd0, 1'b1).d;
    offer(32'd42, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_wr_ready got %b want 1", wr_ready); end
    n_cmp++; if (out_data !== rd) begin n_bad++; $display("FAIL rstmid_out_data got %h want %h", out_data, rd); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_overflow got %b want 0", overflow); end
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wr_ready !== 1'b1 || out_data !== rd) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL rstmid_no_commit got %0d bad cycles want 0", stray); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex();
    test_decimal();
    test_ignored_offer();
    test_reset_mid_convert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
